// File: rtl/uart_tx_framer_pkg.sv
// Shared types and constants for the UART transmit framer and its baud generator.
package uart_tx_framer_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Parallel-side request/status bundle plus the serial line of the UART transmitter.
interface uart_tx_framer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 tx_serial;

    modport master (
        output tx_data, tx_start,
        input  tx_busy, tx_done, tx_serial
    );

    modport slave (
        input  tx_data, tx_start,
        output tx_busy, tx_done, tx_serial
    );
endinterface

// File: rtl/uart_tx_framer_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on terminal count.
module uart_tx_framer_baud_gen
    import uart_tx_framer_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick_c
);
    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;

    assign tick_c = en && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (tick_c) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: frames one parallel word per request as start, LSB-first data,
// optional parity and stop bit(s), with every line level driven from a flop.
module uart_tx_framer
    import uart_tx_framer_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic clk,
    input  logic rst,
    uart_tx_framer_if.slave bus
);
    localparam int unsigned IDX_W = cnt_width(DATA_BITS);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 serial_q, serial_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick_c;

    uart_tx_framer_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == ST_IDLE),
        .en     (state_q != ST_IDLE),
        .tick_c (tick_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            serial_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state; line level and status are decoded from the next state so they
    // land in flops aligned with the state they describe.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        done_d     = 1'b0;
        serial_d   = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.tx_start) begin
                    shift_d    = bus.tx_data;
                    par_d      = (PARITY_ODD != 0) ? ~^bus.tx_data : ^bus.tx_data;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tick_c) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick_c) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick_c) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tick_c) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shift_d[0];
            ST_PARITY: serial_d = par_d;
            default:   serial_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.tx_serial = serial_q;
    assign bus.tx_busy   = busy_q;
    assign bus.tx_done   = done_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: 8E1, 8O2 and 7N1 instances at 4 clocks per bit.
module tb_uart_tx_framer;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   errors = 0;
    int   sel    = 0;

    always #5 clk = ~clk;

    uart_tx_framer_if #(.DATA_BITS(8)) if_a ();
    uart_tx_framer_if #(.DATA_BITS(8)) if_b ();
    uart_tx_framer_if #(.DATA_BITS(7)) if_c ();

    uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        dut_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));
    uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
        dut_b (.clk(clk), .rst(rst_b), .bus(if_b.slave));
    uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        dut_c (.clk(clk), .rst(rst_c), .bus(if_c.slave));

    logic mon_serial, mon_busy, mon_done;
    always_comb begin
        case (sel)
            1:       begin mon_serial = if_b.tx_serial; mon_busy = if_b.tx_busy; mon_done = if_b.tx_done; end
            2:       begin mon_serial = if_c.tx_serial; mon_busy = if_c.tx_busy; mon_done = if_c.tx_done; end
            default: begin mon_serial = if_a.tx_serial; mon_busy = if_a.tx_busy; mon_done = if_a.tx_done; end
        endcase
    end

    // line: slot 0 (start bit) at bit 11, following slots to the right
    typedef struct {
        int          sel;
        logic [8:0]  data;
        logic [11:0] line;
        int          nbits;
        logic [8:0]  mid;
        bit          poke;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [8:0] d);
        case (sel)
            1:       begin if_b.tx_start = st; if_b.tx_data = d[7:0]; end
            2:       begin if_c.tx_start = st; if_c.tx_data = d[6:0]; end
            default: begin if_a.tx_start = st; if_a.tx_data = d[7:0]; end
        endcase
    endtask

    // Called at a negedge with tx_start already high; checks every cycle of the frame.
    task automatic expect_frame(input logic [11:0] line, input int nbits, input bit hold,
                                input logic [8:0] mid, input bit poke);
        int   last;
        logic exp_s;
        last = hold ? CPB*nbits + 1 : CPB*nbits + 2;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) drive(hold, mid);
            if (poke && k == 20) drive(1'b1, 9'h1FF);
            if (poke && k == 21) drive(1'b0, mid);
            exp_s = (k <= CPB*nbits) ? line[11 - (k-1)/CPB] : 1'b1;
            chk($sformatf("serial sel%0d k%0d", sel, k), mon_serial, exp_s);
            chk($sformatf("busy sel%0d k%0d", sel, k), mon_busy, k <= CPB*nbits);
            chk($sformatf("done sel%0d k%0d", sel, k), mon_done, k == CPB*nbits + 1);
        end
    endtask

    initial begin
        vecs[0] = '{0, 9'h0A5, 12'b010100101010, 11, 9'h05A, 1'b0};
        vecs[1] = '{1, 9'h001, 12'b010000000011, 12, 9'h0FE, 1'b0};
        vecs[2] = '{2, 9'h07F, 12'b011111111000,  9, 9'h000, 1'b0};
        vecs[3] = '{0, 9'h000, 12'b000000000010, 11, 9'h000, 1'b1};
        vecs[4] = '{0, 9'h080, 12'b000000001110, 11, 9'h07F, 1'b0};
        vecs[5] = '{1, 9'h0FF, 12'b011111111111, 12, 9'h000, 1'b0};
        vecs[6] = '{2, 9'h02A, 12'b001010101000,  9, 9'h055, 1'b0};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int s = 0; s < 3; s++) begin sel = s; drive(1'b0, 9'h000); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            chk($sformatf("reset serial sel%0d", s), mon_serial, 1'b1);
            chk($sformatf("reset busy sel%0d", s), mon_busy, 1'b0);
            chk($sformatf("reset done sel%0d", s), mon_done, 1'b0);
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            sel = vecs[i].sel;
            drive(1'b1, vecs[i].data);
            expect_frame(vecs[i].line, vecs[i].nbits, 1'b0, vecs[i].mid, vecs[i].poke);
            @(negedge clk);
        end

        // Back-to-back: start held, second frame starts right after the done cycle.
        sel = 0;
        drive(1'b1, 9'h055);
        expect_frame(12'b010101010010, 11, 1'b1, 9'h0AA, 1'b0);
        expect_frame(12'b001010101010, 11, 1'b0, 9'h0AA, 1'b0);

        // Reset during data bit 3 aborts the frame with no done pulse.
        @(negedge clk);
        drive(1'b1, 9'h0A5);
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) drive(1'b0, 9'h0A5);
            if (k >= 17) chk($sformatf("bit3 serial k%0d", k), mon_serial, 1'b0);
        end
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        chk("abort serial", mon_serial, 1'b1);
        chk("abort busy", mon_busy, 1'b0);
        chk("abort done", mon_done, 1'b0);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            chk($sformatf("post-abort done k%0d", k), mon_done, 1'b0);
            chk($sformatf("post-abort serial k%0d", k), mon_serial, 1'b1);
        end

        // Recovery frame after the abort.
        drive(1'b1, 9'h0A5);
        expect_frame(12'b010100101010, 11, 1'b0, 9'h000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
